// File: rtl/requant_pipe.sv
// Four-stage int32 -> int8 requantizer (bias, fixed-point multiply, rounding shift, offset, clamp).
// Define PER_CHANNEL_EN to give bias/multiplier/shift a NUM_CH-entry table indexed by channel.
module requant_pipe #(
    parameter int NUM_CH = 16,
    parameter int CH_W   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [2:0]      cfg_sel,
    input  logic [CH_W-1:0] cfg_ch,
    input  logic [31:0]     cfg_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_acc,
    input  logic [CH_W-1:0] in_ch,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_data,
    output logic            busy
);

    logic advance;
    logic cfg_we;
    logic v1, v2, v3;

    assign advance   = ~out_valid | out_ready;
    assign in_ready  = advance;
    assign busy      = v1 | v2 | v3 | out_valid;
    assign cfg_ready = ~busy;
    assign cfg_we    = cfg_valid & cfg_ready;

    // Shift field is 6-bit signed; -32 is the only value outside +-31.
    function automatic logic signed [5:0] sat_shift(input logic [5:0] d);
        return (d == 6'b10_0000) ? 6'b10_0001 : d;
    endfunction

    logic signed [31:0] sel_bias;
    logic signed [31:0] sel_mult;
    logic signed [5:0]  sel_shift;
    logic signed [31:0] out_offset_q;
    logic signed [7:0]  act_min_q;
    logic signed [7:0]  act_max_q;

`ifdef PER_CHANNEL_EN
    logic signed [31:0] bias_tab  [NUM_CH];
    logic signed [31:0] mult_tab  [NUM_CH];
    logic signed [5:0]  shift_tab [NUM_CH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                bias_tab[i]  <= '0;
                mult_tab[i]  <= 32'h4000_0000;
                shift_tab[i] <= 6'sd1;
            end
        end else if (cfg_we) begin
            case (cfg_sel)
                3'd0:    bias_tab[cfg_ch]  <= cfg_data;
                3'd1:    mult_tab[cfg_ch]  <= cfg_data;
                3'd2:    shift_tab[cfg_ch] <= sat_shift(cfg_data[5:0]);
                default: ;
            endcase
        end
    end

    assign sel_bias  = bias_tab[in_ch];
    assign sel_mult  = mult_tab[in_ch];
    assign sel_shift = shift_tab[in_ch];
`else
    logic signed [31:0] bias_q;
    logic signed [31:0] mult_q;
    logic signed [5:0]  shift_q;
    logic               unused_ch;

    always_ff @(posedge clk) begin
        if (reset) begin
            bias_q  <= '0;
            mult_q  <= 32'h4000_0000;
            shift_q <= 6'sd1;
        end else if (cfg_we) begin
            case (cfg_sel)
                3'd0:    bias_q  <= cfg_data;
                3'd1:    mult_q  <= cfg_data;
                3'd2:    shift_q <= sat_shift(cfg_data[5:0]);
                default: ;
            endcase
        end
    end

    assign sel_bias  = bias_q;
    assign sel_mult  = mult_q;
    assign sel_shift = shift_q;
    assign unused_ch = ^{cfg_ch, in_ch};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            out_offset_q <= '0;
            act_min_q    <= -8'sd128;
            act_max_q    <= 8'sd127;
        end else if (cfg_we) begin
            case (cfg_sel)
                3'd3:    out_offset_q <= cfg_data;
                3'd4:    act_min_q    <= cfg_data[7:0];
                3'd5:    act_max_q    <= cfg_data[7:0];
                default: ;
            endcase
        end
    end

    // S1: bias add and left shift; the right-shift amount travels with the data.
    logic signed [31:0] x_s0, xl_s0;
    logic signed [5:0]  neg_shift;
    logic [4:0]         ls_s0, rs_s0;

    always_comb begin
        x_s0      = in_acc + sel_bias;
        neg_shift = -sel_shift;
        ls_s0     = '0;
        rs_s0     = '0;
        if (sel_shift[5]) rs_s0 = neg_shift[4:0];
        else              ls_s0 = sel_shift[4:0];
        xl_s0 = x_s0 << ls_s0;
    end

    logic signed [31:0] xl_s1, mult_s1;
    logic [4:0]         rs_s1, rs_s2, rs_s3;
    logic signed [63:0] ab_s1, ab_s2;
    logic               ovf_s1, ovf_s2;

    assign ab_s1  = {{32{xl_s1[31]}}, xl_s1} * {{32{mult_s1[31]}}, mult_s1};
    assign ovf_s1 = (xl_s1 == 32'h8000_0000) && (mult_s1 == 32'h8000_0000);

    // S3: round-to-nearest high half, dividing by 2^31 toward zero rather than flooring.
    logic signed [63:0] nudged, biased;
    logic signed [31:0] h_s2, h_s3;

    always_comb begin
        nudged = ab_s2 + (ab_s2[63] ? 64'hFFFF_FFFF_C000_0001 : 64'h0000_0000_4000_0000);
        biased = nudged + (nudged[63] ? 64'h0000_0000_7FFF_FFFF : 64'h0);
        h_s2   = ovf_s2 ? 32'h7FFF_FFFF : biased[62:31];
    end

    // S4: rounding right shift (ties away from zero), output offset, clamp.
    logic [31:0]        mask, rem, thr;
    logic signed [31:0] shr;
    logic signed [32:0] y, t, min33, max33;
    logic [7:0]         clamped;

    always_comb begin
        mask    = (32'd1 << rs_s3) - 32'd1;
        rem     = h_s3 & mask;
        thr     = {1'b0, mask[31:1]} + {31'd0, h_s3[31]};
        shr     = h_s3 >>> rs_s3;
        y       = {shr[31], shr} + {32'd0, rem > thr} + {out_offset_q[31], out_offset_q};
        min33   = {{25{act_min_q[7]}}, act_min_q};
        max33   = {{25{act_max_q[7]}}, act_max_q};
        t       = (y < min33) ? min33 : y;
        clamped = (t > max33) ? act_max_q : t[7:0];
    end

    // All stages move in lockstep; a stalled output freezes the whole pipe.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            xl_s1     <= '0;
            mult_s1   <= '0;
            rs_s1     <= '0;
            ab_s2     <= '0;
            ovf_s2    <= 1'b0;
            rs_s2     <= '0;
            h_s3      <= '0;
            rs_s3     <= '0;
        end else if (advance) begin
            v1        <= in_valid;
            v2        <= v1;
            v3        <= v2;
            out_valid <= v3;
            xl_s1     <= xl_s0;
            mult_s1   <= sel_mult;
            rs_s1     <= rs_s0;
            ab_s2     <= ab_s1;
            ovf_s2    <= ovf_s1;
            rs_s2     <= rs_s1;
            h_s3      <= h_s2;
            rs_s3     <= rs_s2;
            out_data  <= clamped;
        end
    end

endmodule

// File: tb/tb_requant_pipe.sv
// Self-checking bench for requant_pipe: directed cases plus randomized streams scored
// against an arithmetic reference model (division-based, independent of the RTL datapath).
module tb_requant_pipe;

    localparam int NUM_CH = 16;
    localparam int CH_W   = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic [2:0]      cfg_sel = '0;
    logic [CH_W-1:0] cfg_ch = '0;
    logic [31:0]     cfg_data = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_acc = '0;
    logic [CH_W-1:0] in_ch = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [7:0]      out_data;
    logic            busy;

    int tests = 0;
    int fails = 0;

    int m_bias [NUM_CH];
    int m_mult [NUM_CH];
    int m_shift[NUM_CH];
    int m_off, m_min, m_max;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    requant_pipe #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
        .clk(clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel),
        .cfg_ch(cfg_ch), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc), .in_ch(in_ch),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int ch_idx(input logic [CH_W-1:0] c);
`ifdef PER_CHANNEL_EN
        return int'(c);
`else
        return 0;
`endif
    endfunction

    function automatic void reset_mirror();
        for (int i = 0; i < NUM_CH; i++) begin
            m_bias[i]  = 0;
            m_mult[i]  = 32'h4000_0000;
            m_shift[i] = 1;
        end
        m_off = 0;
        m_min = -128;
        m_max = 127;
    endfunction

    function automatic void mirror_write(input logic [2:0] sel, input logic [CH_W-1:0] ch,
                                         input logic [31:0] d);
        logic signed [5:0] s6;
        byte b;
        int c;
        c  = ch_idx(ch);
        s6 = d[5:0];
        b  = d[7:0];
        case (sel)
            3'd0: m_bias[c]  = d;
            3'd1: m_mult[c]  = d;
            3'd2: m_shift[c] = (int'(s6) < -31) ? -31 : int'(s6);
            3'd3: m_off      = d;
            3'd4: m_min      = b;
            3'd5: m_max      = b;
            default: ;
        endcase
    endfunction

    // Reference: plain integer arithmetic on the written config values.
    function automatic logic [7:0] model(input logic [31:0] acc, input logic [CH_W-1:0] ch);
        int c, sh, x, xl, rs;
        longint ab, h, d, q, rm, y;
        c  = ch_idx(ch);
        sh = m_shift[c];
        x  = int'(acc) + m_bias[c];
        xl = (sh > 0) ? (x << sh) : x;
        rs = (sh < 0) ? -sh : 0;
        if (xl == int'(32'h8000_0000) && m_mult[c] == int'(32'h8000_0000)) begin
            h = 64'sd2147483647;
        end else begin
            ab = longint'(xl) * longint'(m_mult[c]);
            if (ab >= 0) h = ab + 64'sd1073741824;
            else         h = ab + 64'sd1 - 64'sd1073741824;
            h = h / 64'sd2147483648;
        end
        if (rs == 0) begin
            q = h;
        end else begin
            d  = longint'(1) << rs;
            q  = h / d;
            rm = h - q * d;
            if (rm < 0) rm = -rm;
            if (2 * rm >= d) q = (h < 0) ? q - 1 : q + 1;
        end
        y = q + longint'(m_off);
        if (y < longint'(m_min)) y = m_min;
        if (y > longint'(m_max)) y = m_max;
        return y[7:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: record transfers that the coming edge performs, then step past it.
    task automatic tick();
        if (reset) begin
            reset_mirror();
        end else begin
            if (out_valid && out_ready) got_q.push_back(out_data);
            if (in_valid && in_ready)   exp_q.push_back(model(in_acc, in_ch));
            if (cfg_valid && cfg_ready) mirror_write(cfg_sel, cfg_ch, cfg_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check("drain_busy", busy, 0);
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic cfg_write(input logic [2:0] sel, input logic [CH_W-1:0] ch, input logic [31:0] d);
        int n = 0;
        cfg_valid = 1'b1;
        cfg_sel   = sel;
        cfg_ch    = ch;
        cfg_data  = d;
        #1;
        while (!cfg_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("cfg_ready_timeout", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic apply_stimulus(input string tag, input logic [31:0] acc, input logic [7:0] exp);
        int lat;
        in_valid = 1'b1;
        in_acc   = acc;
        in_ch    = CH_W'($urandom);
        #1;
        check({tag, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, 4);
        check(tag, out_data, exp);
        tick();
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic check_output(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check(tag, got_q[i], exp_q[i]);
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        int idx, stall_left, cyc, n, accepted;
        bit first_seen, seen;

        reset_mirror();
        tick();
        tick();
        reset = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_in_ready", in_ready, 1);

        apply_stimulus("ident_100", 32'd100, 8'h64);
        apply_stimulus("ident_m300", 32'hFFFF_FED4, 8'h80);
        apply_stimulus("ident_500", 32'd500, 8'h7F);

        cfg_write(3'd0, '0, 32'hFFFF_FFCE);
        cfg_write(3'd2, '0, 32'hFFFF_FFFE);
        cfg_write(3'd3, '0, 32'hFFFF_FFFB);
        apply_stimulus("round_1000", 32'd1000, 8'h72);

        cfg_write(3'd0, '0, 32'd0);
        cfg_write(3'd3, '0, 32'd0);
        cfg_write(3'd2, '0, 32'hFFFF_FFFF);
        apply_stimulus("half_away_m6", 32'hFFFF_FFFA, 8'hFE);

        cfg_write(3'd2, '0, 32'd0);
        cfg_write(3'd1, '0, 32'h8000_0000);
        apply_stimulus("ovf_sat", 32'h8000_0000, 8'h7F);

        cfg_write(3'd1, '0, 32'h4000_0000);
        cfg_write(3'd2, '0, 32'd1);
        cfg_write(3'd4, '0, 32'd10);
        cfg_write(3'd5, '0, 32'hFFFF_FFF6);
        apply_stimulus("min_gt_max", 32'd50, 8'hF6);
        cfg_write(3'd4, '0, 32'hFFFF_FF80);
        cfg_write(3'd5, '0, 32'd127);

        // Backpressure: stream 1..8, stall the consumer for 10 cycles at the first result.
        drain();
        idx = 0;
        stall_left = 0;
        first_seen = 1'b0;
        for (cyc = 0; cyc < 80 && (idx < 8 || busy); cyc++) begin
            in_valid = (idx < 8);
            in_acc   = 32'(idx + 1);
            if (out_valid && !first_seen) begin
                first_seen = 1'b1;
                stall_left = 10;
            end
            out_ready = (stall_left == 0);
            #1;
            if (stall_left > 0) begin
                check("stall_in_ready", in_ready, 0);
                check("stall_hold", out_data, 1);
                stall_left--;
            end
            accepted = int'(in_valid && in_ready);
            tick();
            if (accepted != 0) idx++;
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        check("bp_count", got_q.size(), 8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) check("bp_order", got_q[i], i + 1);
        check_output("bp_model");

        // Config write issued while busy must wait for the drain.
        in_valid = 1'b1;
        in_acc   = 32'd20;
        tick();
        in_valid  = 1'b0;
        cfg_valid = 1'b1;
        cfg_sel   = 3'd3;
        cfg_data  = 32'd3;
        #1;
        check("busy_cfg_ready", cfg_ready, 0);
        n = 0;
        while (!out_valid && n < 12) begin
            tick();
            n++;
        end
        check("busy_old_cfg", out_data, 20);
        while (!cfg_ready && n < 30) begin
            tick();
            n++;
        end
        check("drained_cfg_ready", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
        apply_stimulus("new_cfg", 32'd20, 8'd23);

        // Reset with three items in flight.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_acc   = 32'(30 + i);
            tick();
        end
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        got_q.delete();
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            seen |= out_valid;
            tick();
        end
        check("flush_no_out", seen, 0);
        check("flush_busy", busy, 0);
        apply_stimulus("post_rst", 32'd7, 8'd7);

        // Randomized rounds with random config and random handshakes.
        for (int r = 0; r < 4; r++) begin
            drain();
            for (int k = 0; k < 3; k++) begin
                cfg_write(3'd0, CH_W'($urandom), (r < 2) ? $urandom : $urandom_range(0, 2000) - 1000);
                cfg_write(3'd1, CH_W'($urandom), $urandom);
                cfg_write(3'd2, CH_W'($urandom), $urandom_range(0, 63));
            end
            cfg_write(3'd3, '0, $urandom_range(0, 40) - 20);
            cfg_write(3'd4, '0, (r < 2) ? $urandom : 32'hFFFF_FF80);
            cfg_write(3'd5, '0, (r < 2) ? $urandom : 32'd127);
            idx = 0;
            for (cyc = 0; idx < 100 && cyc < 2000; cyc++) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_acc    = (r == 3) ? $urandom_range(0, 4000) - 2000 : $urandom;
                in_ch     = CH_W'($urandom);
                out_ready = ($urandom_range(0, 3) != 0);
                #1;
                accepted = int'(in_valid && in_ready);
                tick();
                if (accepted != 0) idx++;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            n = 0;
            #1;
            while (busy && n < 100) begin
                tick();
                n++;
            end
            check("rand_drain", busy, 0);
            check_output("rand_stream");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
